router_pipe: RTL and testbench
==============================

Name: router_pipe

Overview:
Parametrised, pipelined successor to the combinational PE router in the string-matching array. Forward path: a valid/ready-handshaked, STAGES-deep register pipeline that delivers characters, ALU opcodes and enables to num PEs. Three lane-mapping modes are supported: parallel pass, broadcast and systolic shift. Return path: registers PE match results and produces per-beat match summaries plus a saturating hit counter.

Parameters:
DWIDTH, 8, character width in bits
num, 4, number of PE lanes (>=2)
STAGES, 1, forward pipeline depth (1..4)
HCW, 16, hit counter width
CW, $clog2(num+1), width of match_count (derived, localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
mode  in  2  lane mapping: 00 pass, 01 broadcast, 10 shift, 11 pass
in_valid  in  1  upstream beat valid
in_ready  out  1  router can accept a beat this cycle
str_arr  in  num*DWIDTH  characters; lane i = bits [i*DWIDTH +: DWIDTH]
ALU  in  num  per-lane opcode bit
en  in  num  per-lane enable
out_valid  out  1  beat valid toward PEs
pe_ready  in  1  PEs accept a beat this cycle
str_to_pe  out  num*DWIDTH  characters to PEs
ALU_to_pe  out  num  opcode to PEs
en_to_pe  out  num  enables to PEs
result_from_pe  in  num  per-PE match flags
res_valid_in  in  1  result_from_pe valid
hit_clr  in  1  clear hit counter
result  out  num  registered match flags
result_valid  out  1  result valid
match_any  out  1  OR of result
match_count  out  CW  popcount of result
hit_count  out  HCW  number of result beats with match_any

Behaviour:
- Reset: every stage valid, data register and window register clears to 0. out_valid, result, result_valid, match_any, match_count and hit_count are all 0.
- Accept: a beat is accepted when in_valid && in_ready. A beat is transferred to the PEs when out_valid && pe_ready.
- Pipeline: stages s0..s(STAGES-1), each holding {valid, str, ALU, en}.
  - The last stage may load when it is empty or pe_ready=1.
  - Stage k may load when stage k+1 may load, or when stage k is empty (bubble-collapsing).
  - in_ready = "s0 may load". It is combinational from pe_ready and the valid bits only.
- Latency: with no stalls, a beat accepted in cycle t appears on the outputs in cycle t+STAGES.
- Stall: while pe_ready=0 and out_valid=1, the outputs hold stable and no beat is lost or duplicated.
- Outputs: str_to_pe, ALU_to_pe, en_to_pe and out_valid are driven straight from the last stage.
- Mode mapping: mode is sampled per beat at acceptance and applied to the data entering s0. ALU and en always pass unchanged.
  - 00/11: lane i to lane i.
  - 01: str lane 0 is copied to all lanes.
  - 10: num*DWIDTH window register W. On each accepted mode-10 beat, W' = {W lanes 0..num-2 shifted up one lane, new lane 0 = str_arr lane 0}, and s0 loads W'.
  - W changes only on accepted mode-10 beats. It holds across other modes and stalls, and clears only on reset.
- Mode change mid-stream: beats already in the pipeline keep their original mapping.
- Return path: every cycle, result <= result_from_pe and result_valid <= res_valid_in (1-cycle latency, no back-pressure).
  - match_any and match_count are registered in the same cycle as result, computed from result_from_pe.
  - When res_valid_in=0, result, match_any and match_count are forced to 0.
- Hit counter:
  - hit_count increments by 1 in each cycle where res_valid_in && |result_from_pe.
  - It saturates at 2^HCW-1.
  - When hit_clr and an increment coincide, hit_count becomes 0 (clear wins).
- Reset mid-operation: in-flight beats are discarded and in_ready=1 in the first cycle after reset deasserts.

Test Plan:
- Pass, STAGES=2, num=4, pe_ready=1, str_arr=0x44332211 accepted at t0 -> out_valid=1 with str_to_pe=0x44332211 at t0+2; ALU and en echoed.
- Broadcast, str_arr=0x44332211 -> str_to_pe=0x11111111.
- Shift, four accepted beats with lane 0 = 0x41,0x42,0x43,0x44 (other lanes ignored) -> fourth output str_to_pe=0x41424344. An intervening mode-00 beat leaves W unchanged.
- Back-pressure: STAGES=2, pe_ready=0 for 5 cycles with continuous in_valid.
  - in_ready falls after 2 beats are held.
  - Outputs stay stable during the stall.
  - On release, beats emerge in order with none dropped or duplicated.
- Results: result_from_pe=4'b1011 with res_valid_in=1 -> next cycle result=1011, match_any=1, match_count=3, hit_count+1. With res_valid_in=0 -> all three are 0.
- Hit counter: HCW=4, 20 matching beats -> hit_count=15. hit_clr together with a matching beat -> hit_count=0. Reset mid-stream -> out_valid=0 and hit_count=0.

Source files
------------

// File: rtl/router_pipe_if.sv
// Forward-path bus of the PE router: upstream beat handshake (with per-beat
// lane-mapping mode) and the downstream handshake toward the PE array.
//   master : upstream source + PE sink side (drives beats and pe_ready)
//   slave  : the router (drives in_ready and the PE-facing beat)
interface router_pipe_if #(
  parameter int DWIDTH = 8,
  parameter int num    = 4
);
  logic [1:0]            mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [num*DWIDTH-1:0] str_arr;
  logic [num-1:0]        ALU;
  logic [num-1:0]        en;
  logic                  out_valid;
  logic                  pe_ready;
  logic [num*DWIDTH-1:0] str_to_pe;
  logic [num-1:0]        ALU_to_pe;
  logic [num-1:0]        en_to_pe;

  modport master (
    output mode, in_valid, str_arr, ALU, en, pe_ready,
    input  in_ready, out_valid, str_to_pe, ALU_to_pe, en_to_pe
  );

  modport slave (
    input  mode, in_valid, str_arr, ALU, en, pe_ready,
    output in_ready, out_valid, str_to_pe, ALU_to_pe, en_to_pe
  );
endinterface

// File: rtl/router_pipe.sv
// Pipelined PE router.
// Forward path: valid/ready pipeline of STAGES registers carrying
// {str, ALU, en} to num PE lanes, with per-beat lane mapping
// (pass / broadcast / systolic shift) applied on entry.
// Return path: registers PE match flags, their OR and popcount, and keeps a
// saturating count of matching result beats.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : forward handshake in (mode, in_valid/in_ready, str_arr,
//                       ALU, en) and out (out_valid/pe_ready, *_to_pe)
//   result_from_pe    : per-PE match flags, qualified by res_valid_in
//   hit_clr           : clears hit_count (wins over a same-cycle increment)
//   result, result_valid, match_any, match_count, hit_count : return path

// One lane of the entry mapping. shift_in is the value this lane takes in
// shift mode (lane 0 gets the new character, lane i gets window lane i-1).
module router_pipe_lane #(
  parameter int DWIDTH = 8
) (
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] own,
  input  logic [DWIDTH-1:0] lane0,
  input  logic [DWIDTH-1:0] shift_in,
  output logic [DWIDTH-1:0] mapped
);
  always_comb begin
    mapped = own;
    case (mode)
      2'b01:   mapped = lane0;
      2'b10:   mapped = shift_in;
      default: mapped = own;
    endcase
  end
endmodule

module router_pipe #(
  parameter int DWIDTH = 8,
  parameter int num    = 4,
  parameter int STAGES = 1,
  parameter int HCW    = 16,
  localparam int CW    = $clog2(num + 1)
) (
  input  logic              clk,
  input  logic              reset,
  router_pipe_if.slave      bus,
  input  logic [num-1:0]    result_from_pe,
  input  logic              res_valid_in,
  input  logic              hit_clr,
  output logic [num-1:0]    result,
  output logic              result_valid,
  output logic              match_any,
  output logic [CW-1:0]     match_count,
  output logic [HCW-1:0]    hit_count
);
  localparam int W = num * DWIDTH;

  // ---------------- entry mapping ----------------
  // Only window lanes 0..num-2 are ever read back (lane num-1 is shifted
  // out on the next shift beat), so just those lanes are stored.
  logic [(num-1)*DWIDTH-1:0] win;
  logic [W-1:0]              win_next;
  logic [W-1:0]              mapped;
  logic                      accept;

  for (genvar i = 0; i < num; i++) begin : g_lane
    logic [DWIDTH-1:0] sh;
    if (i == 0) begin : g_l0
      assign sh = bus.str_arr[0 +: DWIDTH];
    end else begin : g_ln
      assign sh = win[(i-1)*DWIDTH +: DWIDTH];
    end
    assign win_next[i*DWIDTH +: DWIDTH] = sh;

    router_pipe_lane #(.DWIDTH(DWIDTH)) u_lane (
      .mode     (bus.mode),
      .own      (bus.str_arr[i*DWIDTH +: DWIDTH]),
      .lane0    (bus.str_arr[0 +: DWIDTH]),
      .shift_in (sh),
      .mapped   (mapped[i*DWIDTH +: DWIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)                            win <= '0;
    else if (accept && bus.mode == 2'b10) win <= win_next[(num-1)*DWIDTH-1:0];
  end

  // ---------------- forward pipeline ----------------
  // Stage k loads when any stage from k to the last is empty or the PEs are
  // taking a beat; this collapses bubbles and keeps in_ready free of data.
  logic [STAGES:1]          vld_pipe, ld, src_vld;
  logic [STAGES:1][W-1:0]   str_pipe, src_str;
  logic [STAGES:1][num-1:0] alu_pipe, en_pipe, src_alu, src_en;

  always_comb begin
    logic empty_tail;
    empty_tail = 1'b0;
    ld = '0;
    for (int k = STAGES; k >= 1; k--) begin
      empty_tail = empty_tail | ~vld_pipe[k];
      ld[k] = bus.pe_ready | empty_tail;
    end
  end

  always_comb begin
    src_vld    = '0;
    src_str    = '0;
    src_alu    = '0;
    src_en     = '0;
    src_vld[1] = bus.in_valid;
    src_str[1] = mapped;
    src_alu[1] = bus.ALU;
    src_en[1]  = bus.en;
    for (int k = 2; k <= STAGES; k++) begin
      src_vld[k] = vld_pipe[k-1];
      src_str[k] = str_pipe[k-1];
      src_alu[k] = alu_pipe[k-1];
      src_en[k]  = en_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      str_pipe <= '0;
      alu_pipe <= '0;
      en_pipe  <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= src_vld[k];
          str_pipe[k] <= src_str[k];
          alu_pipe[k] <= src_alu[k];
          en_pipe[k]  <= src_en[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld[1];
  assign accept        = bus.in_valid & ld[1];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.str_to_pe = str_pipe[STAGES];
  assign bus.ALU_to_pe = alu_pipe[STAGES];
  assign bus.en_to_pe  = en_pipe[STAGES];

  // ---------------- return path ----------------
  logic [CW-1:0] pc;
  logic          hit;

  always_comb begin
    pc = '0;
    for (int i = 0; i < num; i++) pc = pc + CW'(result_from_pe[i]);
  end

  assign hit = res_valid_in & (|result_from_pe);

  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      match_any    <= 1'b0;
      match_count  <= '0;
      hit_count    <= '0;
    end else begin
      result       <= res_valid_in ? result_from_pe : '0;
      result_valid <= res_valid_in;
      match_any    <= hit;
      match_count  <= res_valid_in ? pc : '0;
      if (hit_clr)                     hit_count <= '0;
      else if (hit && hit_count != '1) hit_count <= hit_count + HCW'(1);
    end
  end
endmodule

// File: tb/tb_router_pipe.sv
// Scoreboard bench for router_pipe: each accepted beat pushes its expected
// PE-side beat (from a small mapping model) and each PE transfer pops/compares.
module tb_router_pipe;
  localparam int DW = 8, N = 4, ST = 2, HCW = 4;
  localparam int CW = $clog2(N + 1);

  logic clk = 0, reset;
  logic [N-1:0] result_from_pe, result;
  logic res_valid_in, hit_clr, result_valid, match_any;
  logic [CW-1:0] match_count;
  logic [HCW-1:0] hit_count;

  router_pipe_if #(.DWIDTH(DW), .num(N)) bus ();

  router_pipe #(.DWIDTH(DW), .num(N), .STAGES(ST), .HCW(HCW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .result_from_pe(result_from_pe), .res_valid_in(res_valid_in),
    .hit_clr(hit_clr), .result(result), .result_valid(result_valid),
    .match_any(match_any), .match_count(match_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] str;
    logic [3:0]  alu;
    logic [3:0]  en;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] w_m;
  logic [31:0] last_str;
  int n_cmp = 0, n_err = 0, n_acc = 0, cyc = 0;
  bit lat_chk = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      w_m = '0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("spurious_beat", 1, 0);
        else if (bus.pe_ready) begin
          exp_t e;
          e = q.pop_front();
          chk("str", bus.str_to_pe, e.str);
          chk("alu", bus.ALU_to_pe, e.alu);
          chk("en", bus.en_to_pe, e.en);
          if (lat_chk) chk("latency", cyc - e.cyc, ST);
          last_str = bus.str_to_pe;
        end else begin
          chk("stall_str", bus.str_to_pe, q[0].str);
          chk("stall_en", bus.en_to_pe, q[0].en);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        case (bus.mode)
          2'b01:   e.str = {4{bus.str_arr[7:0]}};
          2'b10:   begin w_m = {w_m[23:0], bus.str_arr[7:0]}; e.str = w_m; end
          default: e.str = bus.str_arr;
        endcase
        e.alu = bus.ALU;
        e.en  = bus.en;
        e.cyc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  // call at posedge+1; returns at posedge+1 after the beat is taken
  task automatic send(input logic [1:0] m, input logic [31:0] s,
                      input logic [3:0] a, input logic [3:0] e);
    int t = 0;
    bus.mode = m; bus.str_arr = s; bus.ALU = a; bus.en = e; bus.in_valid = 1;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 50);
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clk); t++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic acc;
    int a0, idx;
    reset = 1; bus.in_valid = 0; bus.pe_ready = 0; bus.mode = 0;
    bus.str_arr = 0; bus.ALU = 0; bus.en = 0;
    result_from_pe = 0; res_valid_in = 0; hit_clr = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_match_any", match_any, 0);
    chk("rst_match_count", match_count, 0);
    chk("rst_hit", hit_count, 0);
    step();

    // pass, broadcast, shift (with a pass beat in between)
    bus.pe_ready = 1;
    send(2'b00, 32'h44332211, 4'b1010, 4'b0110); drain();
    chk("pass_str", last_str, 32'h44332211);
    send(2'b01, 32'h44332211, 4'b0101, 4'b1001); drain();
    chk("bcast_str", last_str, 32'h11111111);
    send(2'b10, 32'hAABBCC41, 4'h1, 4'hF);
    send(2'b10, 32'hAABBCC42, 4'h2, 4'hF);
    send(2'b00, 32'h99887766, 4'h3, 4'hE);
    send(2'b11, 32'h12345678, 4'h4, 4'hD);
    send(2'b10, 32'hAABBCC43, 4'h5, 4'hF);
    send(2'b10, 32'hAABBCC44, 4'h6, 4'hF);
    drain();
    chk("shift4_str", last_str, 32'h41424344);

    // back-pressure with alternating modes
    lat_chk = 0;
    a0 = n_acc; idx = 0;
    bus.pe_ready = 0; bus.in_valid = 1;
    bus.mode = 2'b00; bus.str_arr = 32'hA0B0C0D0; bus.ALU = 4'h0; bus.en = 4'h0;
    for (int c = 0; c < 11; c++) begin
      if (c == 5) begin
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_accepts", n_acc - a0, 2);
        bus.pe_ready = 1;
      end
      @(negedge clk); acc = bus.in_ready;
      step();
      if (acc) begin
        idx++;
        bus.mode = idx[0] ? 2'b01 : 2'b00;
        bus.str_arr = 32'hA0B0C0D0 + 32'(idx * 32'h01010101);
        bus.ALU = 4'(idx); bus.en = ~4'(idx);
      end
    end
    bus.in_valid = 0;
    drain();

    // return path
    result_from_pe = 4'b1011; res_valid_in = 1; step();
    chk("res_result", result, 4'b1011);
    chk("res_valid", result_valid, 1);
    chk("res_any", match_any, 1);
    chk("res_count", match_count, 3);
    chk("res_hit", hit_count, 1);
    result_from_pe = 4'b1111; res_valid_in = 0; step();
    chk("nov_result", result, 0);
    chk("nov_valid", result_valid, 0);
    chk("nov_any", match_any, 0);
    chk("nov_count", match_count, 0);
    chk("nov_hit", hit_count, 1);
    result_from_pe = 4'b0000; res_valid_in = 1; step();
    chk("zero_any", match_any, 0);
    chk("zero_valid", result_valid, 1);
    chk("zero_hit", hit_count, 1);

    // saturation, clear priority
    result_from_pe = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 9) chk("hit_mid", hit_count, 11);
    end
    chk("hit_sat", hit_count, 15);
    chk("cnt_0110", match_count, 2);
    hit_clr = 1; step();
    chk("hit_clr_wins", hit_count, 0);
    hit_clr = 0; step();
    chk("hit_after_clr", hit_count, 1);
    res_valid_in = 0;

    // reset mid-stream
    bus.pe_ready = 0; bus.in_valid = 1; bus.mode = 2'b10;
    bus.str_arr = 32'h00000077; step(); step();
    bus.in_valid = 0;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    reset = 1; step();
    reset = 0;
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_hit", hit_count, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);
    bus.pe_ready = 1;
    send(2'b10, 32'hFFFFFF55, 4'h9, 4'h3); drain();
    chk("post_rst_window", last_str, 32'h00000055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
